// File: rtl/cc_mim_writable_control_store_if.sv
// Bus bundle for the writable control store: fetch and write requests from the sequencer,
// and the microword plus status flags returned by the store.
interface cc_mim_writable_control_store_if #(
   parameter int DATAWIDTH_OUTPUT_BUS = 41,
   parameter int DATAWIDTH_INPUT_BUS  = 11
);
   logic [DATAWIDTH_INPUT_BUS-1:0]  CC_MIM_WCS_rdAddr_InBUS;
   logic                            CC_MIM_WCS_rdEn_In;
   logic [DATAWIDTH_OUTPUT_BUS-1:0] CC_MIM_WCS_data_OutBUS;
   logic                            CC_MIM_WCS_rdValid_Out;
   logic                            CC_MIM_WCS_wrEn_In;
   logic [DATAWIDTH_INPUT_BUS-1:0]  CC_MIM_WCS_wrAddr_InBUS;
   logic [DATAWIDTH_OUTPUT_BUS-1:0] CC_MIM_WCS_wrData_InBUS;
   logic                            CC_MIM_WCS_ready_Out;
   logic                            CC_MIM_WCS_initBusy_Out;

   modport master (
      output CC_MIM_WCS_rdAddr_InBUS, CC_MIM_WCS_rdEn_In,
             CC_MIM_WCS_wrEn_In, CC_MIM_WCS_wrAddr_InBUS, CC_MIM_WCS_wrData_InBUS,
      input  CC_MIM_WCS_data_OutBUS, CC_MIM_WCS_rdValid_Out,
             CC_MIM_WCS_ready_Out, CC_MIM_WCS_initBusy_Out
   );

   modport slave (
      input  CC_MIM_WCS_rdAddr_InBUS, CC_MIM_WCS_rdEn_In,
             CC_MIM_WCS_wrEn_In, CC_MIM_WCS_wrAddr_InBUS, CC_MIM_WCS_wrData_InBUS,
      output CC_MIM_WCS_data_OutBUS, CC_MIM_WCS_rdValid_Out,
             CC_MIM_WCS_ready_Out, CC_MIM_WCS_initBusy_Out
   );
endinterface

// File: rtl/cc_mim_writable_control_store.sv
// Writable microcode control store: clears every word after reset, then serves registered
// one-cycle fetches and single-word writes with write-first forwarding.
module cc_mim_writable_control_store #(
   parameter int DATAWIDTH_OUTPUT_BUS = 41,
   parameter int DATAWIDTH_INPUT_BUS  = 11,
   parameter int DEPTH                = 2**DATAWIDTH_INPUT_BUS
) (
   input logic                            CC_MIM_WCS_CLOCK_50,
   input logic                            CC_MIM_WCS_RESET_InLow,
   cc_mim_writable_control_store_if.slave wcs
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [DATAWIDTH_INPUT_BUS:0] DEPTH_A  = (DATAWIDTH_INPUT_BUS+1)'(DEPTH);
   localparam logic [CNT_W-1:0]             LAST_CNT = CNT_W'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e                          state_q, state_d;
   logic [CNT_W-1:0]                clr_cnt_q, clr_cnt_d;
   logic [DATAWIDTH_OUTPUT_BUS-1:0] data_q, data_d;
   logic                            rd_valid_q, rd_valid_d;
   logic [DATAWIDTH_OUTPUT_BUS-1:0] mem_q [DEPTH];

   logic                            mem_we;
   logic [IDX_W-1:0]                mem_idx;
   logic [DATAWIDTH_OUTPUT_BUS-1:0] mem_wdata;
   logic                            rd_in_range, wr_in_range;
   logic [IDX_W-1:0]                rd_idx, wr_idx;

   assign rd_in_range = {1'b0, wcs.CC_MIM_WCS_rdAddr_InBUS} < DEPTH_A;
   assign wr_in_range = {1'b0, wcs.CC_MIM_WCS_wrAddr_InBUS} < DEPTH_A;
   assign rd_idx      = wcs.CC_MIM_WCS_rdAddr_InBUS[IDX_W-1:0];
   assign wr_idx      = wcs.CC_MIM_WCS_wrAddr_InBUS[IDX_W-1:0];

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      data_d     = data_q;
      rd_valid_d = 1'b0;
      mem_we     = 1'b0;
      mem_idx    = wr_idx;
      mem_wdata  = wcs.CC_MIM_WCS_wrData_InBUS;
      unique case (state_q)
         ST_INIT: begin
            // The single write port is borrowed by the clear sweep; user traffic is ignored.
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q[IDX_W-1:0];
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_CNT) state_d = ST_RUN;
         end
         ST_RUN: begin
            mem_we = wcs.CC_MIM_WCS_wrEn_In && wr_in_range;
            if (wcs.CC_MIM_WCS_rdEn_In) begin
               rd_valid_d = 1'b1;
               if (!rd_in_range)                    data_d = '0;
               else if (mem_we && wr_idx == rd_idx) data_d = wcs.CC_MIM_WCS_wrData_InBUS;
               else                                 data_d = mem_q[rd_idx];
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CC_MIM_WCS_CLOCK_50 or negedge CC_MIM_WCS_RESET_InLow) begin
      if (!CC_MIM_WCS_RESET_InLow) begin
         state_q    <= ST_INIT;
         clr_cnt_q  <= '0;
         data_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         data_q     <= data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // NOTE: the array has no reset so it maps to RAM; the INIT sweep provides the zero contents.
   always_ff @(posedge CC_MIM_WCS_CLOCK_50) begin
      if (mem_we) mem_q[mem_idx] <= mem_wdata;
   end

   assign wcs.CC_MIM_WCS_data_OutBUS  = data_q;
   assign wcs.CC_MIM_WCS_rdValid_Out  = rd_valid_q;
   assign wcs.CC_MIM_WCS_initBusy_Out = (state_q == ST_INIT);
   assign wcs.CC_MIM_WCS_ready_Out    = (state_q == ST_RUN);
endmodule

// File: tb/tb_cc_mim_writable_control_store.sv
// Bench for the writable control store: a full-depth store checked against an array model
// under directed and random traffic, plus a 16-word store for out-of-range addressing.
module tb_cc_mim_writable_control_store;
   localparam int DW      = 41;
   localparam int AW      = 11;
   localparam int DEPTH_A = 2048;
   localparam int DEPTH_B = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cc_mim_writable_control_store_if #(.DATAWIDTH_OUTPUT_BUS(DW), .DATAWIDTH_INPUT_BUS(AW)) ifa ();
   cc_mim_writable_control_store_if #(.DATAWIDTH_OUTPUT_BUS(DW), .DATAWIDTH_INPUT_BUS(AW)) ifb ();

   cc_mim_writable_control_store #(
      .DATAWIDTH_OUTPUT_BUS(DW), .DATAWIDTH_INPUT_BUS(AW)
   ) dut_a (
      .CC_MIM_WCS_CLOCK_50(clk), .CC_MIM_WCS_RESET_InLow(rst_n), .wcs(ifa.slave)
   );

   cc_mim_writable_control_store #(
      .DATAWIDTH_OUTPUT_BUS(DW), .DATAWIDTH_INPUT_BUS(AW), .DEPTH(DEPTH_B)
   ) dut_b (
      .CC_MIM_WCS_CLOCK_50(clk), .CC_MIM_WCS_RESET_InLow(rst_n), .wcs(ifb.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model for store A: contents, last fetched word, and whether it is running.
   logic [DW-1:0] ref_a [DEPTH_A];
   logic [DW-1:0] exp_data;
   bit            a_run;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      ifa.CC_MIM_WCS_rdEn_In = 1'b0; ifa.CC_MIM_WCS_rdAddr_InBUS = '0;
      ifa.CC_MIM_WCS_wrEn_In = 1'b0; ifa.CC_MIM_WCS_wrAddr_InBUS = '0;
      ifa.CC_MIM_WCS_wrData_InBUS = '0;
      ifb.CC_MIM_WCS_rdEn_In = 1'b0; ifb.CC_MIM_WCS_rdAddr_InBUS = '0;
      ifb.CC_MIM_WCS_wrEn_In = 1'b0; ifb.CC_MIM_WCS_wrAddr_InBUS = '0;
      ifb.CC_MIM_WCS_wrData_InBUS = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH_A; i++) ref_a[i] = '0;
      exp_data = '0;
      a_run    = 1'b0;
   endtask

   // One cycle of traffic on store A, checked against the model.
   task automatic a_op(input bit rd, input logic [AW-1:0] ra, input bit wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input string tag);
      bit exp_valid;
      @(negedge clk);
      ifa.CC_MIM_WCS_rdEn_In = rd;  ifa.CC_MIM_WCS_rdAddr_InBUS = ra;
      ifa.CC_MIM_WCS_wrEn_In = wr;  ifa.CC_MIM_WCS_wrAddr_InBUS = wa;
      ifa.CC_MIM_WCS_wrData_InBUS = wd;
      exp_valid = a_run && rd;
      if (a_run && rd) begin
         if (int'(ra) >= DEPTH_A)  exp_data = '0;
         else if (wr && wa == ra)  exp_data = wd;
         else                      exp_data = ref_a[ra];
      end
      if (a_run && wr && int'(wa) < DEPTH_A) ref_a[wa] = wd;
      @(posedge clk); #1;
      check({tag, "_data"},  ifa.CC_MIM_WCS_data_OutBUS, exp_data);
      check({tag, "_valid"}, ifa.CC_MIM_WCS_rdValid_Out, exp_valid);
      check({tag, "_ready"}, ifa.CC_MIM_WCS_ready_Out, a_run);
   endtask

   // One cycle of traffic on store B with explicit expectations.
   task automatic b_op(input bit rd, input logic [AW-1:0] ra, input bit wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit ev, input logic [DW-1:0] ed, input string tag);
      @(negedge clk);
      ifb.CC_MIM_WCS_rdEn_In = rd;  ifb.CC_MIM_WCS_rdAddr_InBUS = ra;
      ifb.CC_MIM_WCS_wrEn_In = wr;  ifb.CC_MIM_WCS_wrAddr_InBUS = wa;
      ifb.CC_MIM_WCS_wrData_InBUS = wd;
      @(posedge clk); #1;
      check({tag, "_data"},  ifb.CC_MIM_WCS_data_OutBUS, ed);
      check({tag, "_valid"}, ifb.CC_MIM_WCS_rdValid_Out, ev);
   endtask

   // Assert reset, check the asynchronous clear, then release on a falling edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_data"},  ifa.CC_MIM_WCS_data_OutBUS, '0);
      check({tag, "_rst_valid"}, ifa.CC_MIM_WCS_rdValid_Out, 1'b0);
      check({tag, "_rst_busy"},  ifa.CC_MIM_WCS_initBusy_Out, 1'b1);
      check({tag, "_rst_ready"}, ifa.CC_MIM_WCS_ready_Out, 1'b0);
      model_clear();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs just after reset release: random requests on A must be ignored; counts INIT length.
   task automatic run_init(input bit with_b);
      int na = 0;
      int nb = -1;
      do begin
         ifa.CC_MIM_WCS_rdEn_In      = 1'($urandom);
         ifa.CC_MIM_WCS_rdAddr_InBUS = AW'($urandom);
         ifa.CC_MIM_WCS_wrEn_In      = 1'($urandom);
         ifa.CC_MIM_WCS_wrAddr_InBUS = AW'($urandom_range(0, 7));
         ifa.CC_MIM_WCS_wrData_InBUS = DW'({$urandom, $urandom});
         @(posedge clk); #1;
         na++;
         check("init_busy",  ifa.CC_MIM_WCS_initBusy_Out, 64'(na < DEPTH_A));
         check("init_ready", ifa.CC_MIM_WCS_ready_Out, 64'(na >= DEPTH_A));
         check("init_valid", ifa.CC_MIM_WCS_rdValid_Out, 1'b0);
         check("init_data",  ifa.CC_MIM_WCS_data_OutBUS, '0);
         if (with_b && nb < 0 && !ifb.CC_MIM_WCS_initBusy_Out) nb = na;
         @(negedge clk);
      end while (ifa.CC_MIM_WCS_initBusy_Out && na < 3000);
      check("init_len_a", 64'(na), 64'(DEPTH_A));
      if (with_b) check("init_len_b", 64'(nb), 64'(DEPTH_B));
      idle_inputs();
      a_run = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] words [4];
      model_clear();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      check("por_data_a",  ifa.CC_MIM_WCS_data_OutBUS, '0);
      check("por_valid_a", ifa.CC_MIM_WCS_rdValid_Out, 1'b0);
      check("por_busy_a",  ifa.CC_MIM_WCS_initBusy_Out, 1'b1);
      check("por_ready_a", ifa.CC_MIM_WCS_ready_Out, 1'b0);
      check("por_busy_b",  ifb.CC_MIM_WCS_initBusy_Out, 1'b1);
      check("por_ready_b", ifb.CC_MIM_WCS_ready_Out, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_init(1'b1);

      a_op(1'b1, 11'd0, 1'b0, '0, '0, "fetch0");
      a_op(1'b0, '0, 1'b1, 11'd1600, 41'h1_0000_0800, "wr1600");
      a_op(1'b1, 11'd1600, 1'b0, '0, '0, "rd1600");
      a_op(1'b1, 11'd12, 1'b1, 11'd12, 41'h0AB, "wf12");
      a_op(1'b1, 11'd12, 1'b1, 11'd13, 41'h0CD, "rd12wr13");
      a_op(1'b1, 11'd13, 1'b0, '0, '0, "rd13");

      b_op(1'b0, '0, 1'b1, 11'd2047, 41'h5, 1'b0, 41'h0, "b_wr2047");
      b_op(1'b1, 11'd2047, 1'b0, '0, '0, 1'b1, 41'h0, "b_rd2047");
      b_op(1'b0, '0, 1'b1, 11'd15, 41'h7, 1'b0, 41'h0, "b_wr15");
      b_op(1'b1, 11'd15, 1'b0, '0, '0, 1'b1, 41'h7, "b_rd15");
      b_op(1'b1, 11'd16, 1'b0, '0, '0, 1'b1, 41'h0, "b_rd16");
      b_op(1'b0, '0, 1'b0, '0, '0, 1'b0, 41'h0, "b_hold");

      for (int i = 0; i < 4; i++) begin
         words[i] = DW'({$urandom, $urandom}) | DW'(1);
         a_op(1'b0, '0, 1'b1, AW'(i), words[i], "stream_wr");
      end
      for (int i = 0; i < 4; i++) a_op(1'b1, AW'(i), 1'b0, '0, '0, "stream_rd");
      a_op(1'b0, '0, 1'b0, '0, '0, "stream_hold");
      check("stream_hold_w3", ifa.CC_MIM_WCS_data_OutBUS, words[3]);

      for (int i = 0; i < 600; i++) begin
         logic [AW-1:0] ra, wa;
         ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         a_op(1'($urandom_range(0, 3) != 0), ra, 1'($urandom), wa,
              DW'({$urandom, $urandom}), "rand");
      end

      a_op(1'b0, '0, 1'b1, 11'd3, 41'h12_3456_7890, "pre_rst_wr3");
      a_op(1'b1, 11'd3, 1'b0, '0, '0, "pre_rst_rd3");
      do_reset("midrun");
      run_init(1'b0);
      a_op(1'b1, 11'd3, 1'b0, '0, '0, "post_run_rd3");

      a_op(1'b0, '0, 1'b1, 11'd3, 41'h0F_0F0F_0F0F, "pre_init_wr3");
      do_reset("first");
      repeat (1000) @(posedge clk);
      #1;
      check("midinit_busy", ifa.CC_MIM_WCS_initBusy_Out, 1'b1);
      do_reset("midinit");
      run_init(1'b0);
      a_op(1'b1, 11'd3, 1'b0, '0, '0, "post_init_rd3");
      a_op(1'b1, 11'd1600, 1'b0, '0, '0, "post_init_rd1600");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
